meriac_morse_keyer: RTL
=======================

# meriac_morse_keyer

Parametrised successor to the fixed-rate Morse player. Walks a 2-bit Morse symbol database from address 0, expands each symbol into correctly timed key-down/key-up intervals using a programmable unit length, and produces both a keying envelope and a gated square-wave side-tone. Supports one-shot and loop playback plus abort, and sits between the tile I/O pins and the `meriac_morse_db` ROM.

## Interface
- `ADDR_W`, 9: ROM address width; the address wraps modulo 2^ADDR_W.
- `UNIT_W`, 16: width of the unit-length divider.
- `TONE_W`, 12: width of the side-tone half-period divider.
- `clk` in 1: single clock, rising-edge.
- `reset_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: begin playback; level-sampled in IDLE only.
- `stop` in 1: abort playback; level-sampled in any non-IDLE state.
- `loop_en` in 1: when 1, END restarts playback at address 0.
- `unit_div` in UNIT_W: one Morse unit lasts `unit_div + 1` clocks; latched on accepted start.
- `tone_div` in TONE_W: tone half-period is `tone_div + 1` clocks; live input.
- `rom_addr` out ADDR_W: registered ROM address.
- `rom_data` in 2: combinational ROM data for `rom_addr`, valid in the same cycle.
- `key` out 1: registered keying envelope, 1 during a mark.
- `tone` out 1: side-tone, equal to `tone_sq & key`.
- `busy` out 1: 1 in every state except IDLE.
- `done` out 1: one-cycle pulse on natural end of a non-looping playback.

## Operation
- Symbol codes: 00 END, 01 DOT (1-unit mark), 10 DASH (3-unit mark), 11 GAP (2-unit space, no mark).
- Every DOT and DASH is followed by a 1-unit space. A GAP after an element therefore yields the standard 3-unit letter gap; GAP GAP yields 5 units, GAP GAP GAP yields 7 units (word gap).
- States:
  - IDLE: if `start` and not `stop`: `rom_addr` <= 0, latch `unit_div`, go to FETCH.
  - FETCH: decode `rom_data`.
    - DOT: units <= 1, go to MARK.
    - DASH: units <= 3, go to MARK.
    - GAP: units <= 2, go to SPACE.
    - END with `loop_en` = 1: `rom_addr` <= 0, stay in FETCH.
    - END with `loop_en` = 0: pulse `done`, go to IDLE.
  - MARK: count `units` unit ticks, then units <= 1 and go to SPACE.
  - SPACE: count `units` unit ticks, then `rom_addr` <= `rom_addr` + 1 (wrapping), go to FETCH.
- Unit prescaler:
  - Cleared on every entry to MARK or SPACE.
  - A tick occurs when the count equals the latched `unit_div`.
  - Durations are therefore exact multiples of U = `unit_div` + 1 clocks.
- Tone divider:
  - Held at 0 with `tone_sq` = 0 while `key` = 0.
  - While `key` = 1 it counts, and `tone_sq` toggles when the count equals `tone_div`, then the count restarts.
  - `tone` therefore always starts low at key-down.
- `stop` in any non-IDLE state: go to IDLE next edge, `key` and `tone` low from the next cycle, no `done`.
- `start` while busy is ignored. `start` and `stop` together in IDLE: stay in IDLE.
- Address wrap from 2^ADDR_W − 1 to 0 is silent; no `done` is generated.

## Timing
- Reset values: state IDLE, `rom_addr` 0, `key` 0, `tone` 0, `busy` 0, `done` 0, all counters 0.
- Start accepted at edge t: FETCH during cycle t+1, `key` rises at edge t+2.
- With U = `unit_div` + 1:
  - DOT occupies 2U + 1 cycles (U mark, U space, 1 FETCH).
  - DASH occupies 4U + 1 cycles.
  - GAP occupies 2U + 1 cycles.
- Each END costs exactly 1 FETCH cycle.
- `done` is asserted in the cycle after the END FETCH, coincident with `busy` falling.
- `tone_div` changes take effect at the next divider restart.

## Structure
- Shared package `meriac_morse_pkg`: symbol codes (SYM_END/DOT/DASH/GAP), state encoding, DOT_UNITS = 1, DASH_UNITS = 3, GAP_UNITS = 2.
- One sub-module, `meriac_morse_tone`, containing the tone divider and gate (ports: clk, reset_n, en, div, tone).
- The FSM, prescaler and address register stay in the top module.

## Test plan
- Reset mid-playback, `reset_n` low for 1 cycle → all outputs at reset values asynchronously; restart after release behaves as from power-on.
- ROM = DOT, END; `unit_div` = 3; `loop_en` = 0; start at t → `key` high cycles t+2..t+5, `done` at t+11, `busy` low from t+11.
- ROM = DASH, GAP, DOT, END; `unit_div` = 0 → `key` pattern 1110 00 10 followed by END, with FETCH cycles low; 4U + 1, 2U + 1 and 2U + 1 spacing exact.
- `loop_en` = 1, ROM = DOT, END, `unit_div` = 1 → period of 6 cycles repeats indefinitely, `done` never asserted.
- `tone_div` = 2 during a dash with `unit_div` = 11 → `tone` 000111… toggling every 3 cycles, low outside the mark.
- `stop` asserted mid-DASH → `key` low next cycle, IDLE, no `done`. `start` + `stop` together in IDLE → stays IDLE. `start` while busy → no restart.

Source files
------------

// File: rtl/meriac_morse_pkg.sv
// Shared definitions for the Morse keyer: symbol codes, state encoding, unit counts.
package meriac_morse_pkg;

    localparam int unsigned SYM_W   = 2;
    localparam int unsigned UNITS_W = 2;

    localparam logic [SYM_W-1:0] SYM_END  = 2'b00;
    localparam logic [SYM_W-1:0] SYM_DOT  = 2'b01;
    localparam logic [SYM_W-1:0] SYM_DASH = 2'b10;
    localparam logic [SYM_W-1:0] SYM_GAP  = 2'b11;

    localparam logic [UNITS_W-1:0] DOT_UNITS  = 2'd1;
    localparam logic [UNITS_W-1:0] DASH_UNITS = 2'd3;
    localparam logic [UNITS_W-1:0] GAP_UNITS  = 2'd2;
    // Inter-element space that follows every mark.
    localparam logic [UNITS_W-1:0] SEP_UNITS  = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_MARK  = 2'd2,
        ST_SPACE = 2'd3
    } state_t;

endpackage

// File: rtl/meriac_morse_tone.sv
// Side-tone square-wave generator gated by the keying envelope.
module meriac_morse_tone #(
    parameter int unsigned TONE_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [TONE_W-1:0] div,
    output logic              tone
);

    logic [TONE_W-1:0] cnt;
    logic [TONE_W-1:0] div_lat;
    logic              tone_sq;

    // Half-period divider; the divisor is re-sampled only at each restart so a live change never truncates a half-period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            div_lat <= '0;
            tone_sq <= 1'b0;
        end else if (!en) begin
            cnt     <= '0;
            div_lat <= div;
            tone_sq <= 1'b0;
        end else if (cnt == div_lat) begin
            cnt     <= '0;
            div_lat <= div;
            tone_sq <= ~tone_sq;
        end else begin
            cnt     <= cnt + TONE_W'(1);
        end
    end

    assign tone = tone_sq & en;

endmodule

// File: rtl/meriac_morse_keyer.sv
// Morse keyer: walks the symbol ROM and produces a timed key envelope plus gated side-tone.
module meriac_morse_keyer
    import meriac_morse_pkg::*;
#(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned UNIT_W = 16,
    parameter int unsigned TONE_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [UNIT_W-1:0] unit_div,
    input  logic [TONE_W-1:0] tone_div,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [SYM_W-1:0]  rom_data,
    output logic              key,
    output logic              tone,
    output logic              busy,
    output logic              done
);

    state_t              state, state_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [UNIT_W-1:0]   unit_lat, unit_lat_n;
    logic [UNIT_W-1:0]   pre_cnt, pre_n;
    logic [UNITS_W-1:0]  units, units_n;
    logic                key_n, busy_n, done_n;
    logic                unit_tick;

    assign unit_tick = (pre_cnt == unit_lat);

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            rom_addr <= '0;
            unit_lat <= '0;
            pre_cnt  <= '0;
            units    <= '0;
            key      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            rom_addr <= addr_n;
            unit_lat <= unit_lat_n;
            pre_cnt  <= pre_n;
            units    <= units_n;
            key      <= key_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // Next-state, prescaler, unit counter and address sequencing.
    always_comb begin
        state_n    = state;
        addr_n     = rom_addr;
        unit_lat_n = unit_lat;
        pre_n      = pre_cnt;
        units_n    = units;
        done_n     = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_n    = ST_FETCH;
                    addr_n     = '0;
                    unit_lat_n = unit_div;
                end
            end
            ST_FETCH: begin
                pre_n = '0;
                case (rom_data)
                    SYM_END: begin
                        if (loop_en) begin
                            addr_n = '0;
                        end else begin
                            state_n = ST_IDLE;
                            done_n  = 1'b1;
                        end
                    end
                    SYM_DOT: begin
                        units_n = DOT_UNITS;
                        state_n = ST_MARK;
                    end
                    SYM_DASH: begin
                        units_n = DASH_UNITS;
                        state_n = ST_MARK;
                    end
                    default: begin
                        units_n = GAP_UNITS;
                        state_n = ST_SPACE;
                    end
                endcase
            end
            ST_MARK: begin
                pre_n = pre_cnt + UNIT_W'(1);
                if (unit_tick) begin
                    pre_n = '0;
                    if (units == UNITS_W'(1)) begin
                        units_n = SEP_UNITS;
                        state_n = ST_SPACE;
                    end else begin
                        units_n = units - UNITS_W'(1);
                    end
                end
            end
            ST_SPACE: begin
                pre_n = pre_cnt + UNIT_W'(1);
                if (unit_tick) begin
                    pre_n = '0;
                    if (units == UNITS_W'(1)) begin
                        units_n = '0;
                        addr_n  = rom_addr + ADDR_W'(1);
                        state_n = ST_FETCH;
                    end else begin
                        units_n = units - UNITS_W'(1);
                    end
                end
            end
        endcase

        // Abort wins over everything in flight; the address is frozen where it was.
        if ((state != ST_IDLE) && stop) begin
            state_n = ST_IDLE;
            addr_n  = rom_addr;
            pre_n   = '0;
            units_n = '0;
            done_n  = 1'b0;
        end

        key_n  = (state_n == ST_MARK);
        busy_n = (state_n != ST_IDLE);
    end

    meriac_morse_tone #(
        .TONE_W (TONE_W)
    ) u_tone (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (key),
        .div     (tone_div),
        .tone    (tone)
    );

endmodule
